// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: step-button inputs and clock-enable outputs of clock_ctrl
//  master (clock_ctrl): in  step_enable, step_sync
//                       out reset_out, pulse_slow, pulse_fast, clock_slow, clock_fast,
//                           game_tick, cpu_div[2:0], cpu_clock, cpu_tick
//  slave (consumers):   the mirror image of master
interface clock_ctrl_if;
  logic       step_enable;
  logic       step_sync;
  logic       reset_out;
  logic       pulse_slow;
  logic       pulse_fast;
  logic       clock_slow;
  logic       clock_fast;
  logic       game_tick;
  logic [2:0] cpu_div;
  logic       cpu_clock;
  logic       cpu_tick;
  modport master (
    input  step_enable, step_sync,
    output reset_out, pulse_slow, pulse_fast, clock_slow, clock_fast,
           game_tick, cpu_div, cpu_clock, cpu_tick
  );
  modport slave (
    output step_enable, step_sync,
    input  reset_out, pulse_slow, pulse_fast, clock_slow, clock_fast,
           game_tick, cpu_div, cpu_clock, cpu_tick
  );
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: single-domain clock-enable generator (dividers, game tick, CPU divider, reset stretch)
//  core_clock  sole clock, rising edge
//  reset       synchronous active-high reset
//  bus         clock_ctrl_if.master: step_enable/step_sync in; reset_out, pulse_*/clock_*,
//              game_tick, cpu_div, cpu_clock, cpu_tick out
//  STEP_MODE_EN defined: single-step mode via step_enable/step_sync; undefined: free run only
module clock_ctrl #(
  parameter int DIV_SLOW    = 33333,
  parameter int DIV_FAST    = 166,
  parameter int RST_STRETCH = 16
) (
  input  logic         core_clock,
  input  logic         reset,
  clock_ctrl_if.master bus
);
  localparam int SW = $clog2(DIV_SLOW);
  localparam int FW = $clog2(DIV_FAST);
  localparam int RW = $clog2(RST_STRETCH + 1);
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic [RW-1:0] rst_cnt;
  logic          reset_out;
  logic          clock_slow;
  logic          clock_fast;
  logic [2:0]    cpu_div;
  logic          cpu_q;
  logic          cpu_tick;
  logic          pulse_slow;
  logic          pulse_fast;
  logic          game_tick;
  logic [2:0]    cpu_inc;
  assign pulse_slow = slow_cnt == SW'(DIV_SLOW - 1);
  assign pulse_fast = fast_cnt == FW'(DIV_FAST - 1);
`ifdef STEP_MODE_EN
  logic step_q;
  logic step_rise;
  always_ff @(posedge core_clock)
    step_q <= reset ? 1'b0 : bus.step_sync;
  assign step_rise = bus.step_sync & ~step_q;
  // Step size follows step_enable combinationally so a mode switch applies on the same cycle
  always_comb begin
    game_tick = bus.step_enable ? step_rise : ~reset_out;
    cpu_inc   = bus.step_enable ? 3'd4 : 3'd1;
  end
`else
  always_comb begin
    game_tick = ~reset_out;
    cpu_inc   = 3'd1;
  end
`endif
  // reset_out drops after RST_STRETCH cycles with reset low
  always_ff @(posedge core_clock) begin
    if (reset) begin
      rst_cnt   <= '0;
      reset_out <= 1'b1;
    end else if (reset_out) begin
      rst_cnt   <= rst_cnt + 1'b1;
      reset_out <= rst_cnt != RW'(RST_STRETCH - 1);
    end
  end
  always_ff @(posedge core_clock) begin
    if (reset) begin
      slow_cnt   <= '0;
      fast_cnt   <= '0;
      clock_slow <= 1'b0;
      clock_fast <= 1'b0;
    end else begin
      slow_cnt   <= pulse_slow ? '0 : slow_cnt + 1'b1;
      fast_cnt   <= pulse_fast ? '0 : fast_cnt + 1'b1;
      clock_slow <= clock_slow ^ pulse_slow;
      clock_fast <= clock_fast ^ pulse_fast;
    end
  end
  // cpu_tick is a registered rise of cpu_div[2], so it lands one cycle after the MSB sets
  always_ff @(posedge core_clock) begin
    if (reset) begin
      cpu_div  <= '0;
      cpu_q    <= 1'b0;
      cpu_tick <= 1'b0;
    end else begin
      cpu_div  <= (game_tick && !reset_out) ? cpu_div + cpu_inc : cpu_div;
      cpu_q    <= cpu_div[2];
      cpu_tick <= cpu_div[2] & ~cpu_q;
    end
  end
  assign bus.reset_out  = reset_out;
  assign bus.pulse_slow = pulse_slow;
  assign bus.pulse_fast = pulse_fast;
  assign bus.clock_slow = clock_slow;
  assign bus.clock_fast = clock_fast;
  assign bus.game_tick  = game_tick;
  assign bus.cpu_div    = cpu_div;
  assign bus.cpu_clock  = cpu_div[2];
  assign bus.cpu_tick   = cpu_tick;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed self-checking bench for clock_ctrl
//  Cycle k = k-th clock period after the last edge that sampled reset high; samples #1 after each edge.
module tb_clock_ctrl;
  logic core_clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cur;
  int   gsum;
  int   tsum;
  clock_ctrl_if bus ();
  clock_ctrl dut (
    .core_clock(core_clock),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 core_clock = ~core_clock;
  task automatic cyc(input int n);
    repeat (n) @(posedge core_clock);
    #1;
  endtask
  task automatic go(input int target);
    cyc(target - cur);
    cur = target;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.step_enable = 1'b0;
    bus.step_sync = 1'b0;
    cyc(3);
    chk("rst_reset_out", bus.reset_out, 1);
    chk("rst_cpu_div", bus.cpu_div, 0);
    chk("rst_game_tick", bus.game_tick, 0);
    chk("rst_clock_fast", bus.clock_fast, 0);
    chk("rst_clock_slow", bus.clock_slow, 0);
    chk("rst_pulse_fast", bus.pulse_fast, 0);
    chk("rst_cpu_tick", bus.cpu_tick, 0);
    reset = 1'b0;
    cur = 1;
    for (int k = 1; k <= 16; k++) begin
      chk("stretch_reset_out", bus.reset_out, 1);
      chk("stretch_cpu_div", bus.cpu_div, 0);
      chk("stretch_game_tick", bus.game_tick, 0);
      go(k + 1);
    end
    for (int i = 0; i < 16; i++) begin
      chk("free_reset_out", bus.reset_out, 0);
      chk("free_game_tick", bus.game_tick, 1);
      chk("free_cpu_div", bus.cpu_div, i % 8);
      chk("free_cpu_clock", bus.cpu_clock, (i % 8) >= 4);
      chk("free_cpu_tick", bus.cpu_tick, (i % 8) == 5);
      go(cur + 1);
    end
    for (int p = 1; p <= 3; p++) begin
      go(166 * p - 1);
      chk("fast_pre_pulse", bus.pulse_fast, 0);
      chk("fast_pre_clock", bus.clock_fast, (p - 1) % 2);
      go(166 * p);
      chk("fast_pulse", bus.pulse_fast, 1);
      go(166 * p + 1);
      chk("fast_post_pulse", bus.pulse_fast, 0);
      chk("fast_post_clock", bus.clock_fast, p % 2);
    end
    chk("slow_idle", bus.pulse_slow, 0);
    go(505);
    chk("pre_step_cpu_div", bus.cpu_div, 0);
`ifdef STEP_MODE_EN
    bus.step_enable = 1'b1;
    chk("step_idle_tick", bus.game_tick, 0);
    go(506);
    chk("step_hold_cpu_div", bus.cpu_div, 0);
    bus.step_sync = 1'b1;
    gsum = 0;
    tsum = 0;
    for (int j = 0; j < 10; j++) begin
      gsum += int'(bus.game_tick);
      tsum += int'(bus.cpu_tick);
      go(cur + 1);
    end
    chk("step_held_ticks", gsum, 1);
    chk("step_held_cpu_ticks", tsum, 1);
    chk("step1_cpu_div", bus.cpu_div, 4);
    chk("step1_cpu_clock", bus.cpu_clock, 1);
    bus.step_sync = 1'b0;
    go(cur + 1);
    bus.step_sync = 1'b1;
    chk("step2_tick", bus.game_tick, 1);
    go(cur + 1);
    chk("step2_cpu_div", bus.cpu_div, 0);
    bus.step_sync = 1'b0;
    chk("step2_release", bus.game_tick, 0);
    go(cur + 1);
    bus.step_sync = 1'b1;
    go(cur + 1);
    chk("step3_cpu_div", bus.cpu_div, 4);
    bus.step_sync = 1'b0;
    bus.step_enable = 1'b0;
    chk("resume_tick", bus.game_tick, 1);
    go(cur + 1);
    chk("resume_cpu_div_a", bus.cpu_div, 5);
    go(cur + 1);
    chk("resume_cpu_div_b", bus.cpu_div, 6);
`else
    bus.step_enable = 1'b1;
    bus.step_sync = 1'b1;
    chk("nostep_tick", bus.game_tick, 1);
    go(cur + 1);
    chk("nostep_cpu_div_a", bus.cpu_div, 1);
    go(cur + 1);
    chk("nostep_cpu_div_b", bus.cpu_div, 2);
    bus.step_enable = 1'b0;
    bus.step_sync = 1'b0;
`endif
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cur = 1;
    chk("midrst_reset_out", bus.reset_out, 1);
    chk("midrst_cpu_div", bus.cpu_div, 0);
    chk("midrst_cpu_tick", bus.cpu_tick, 0);
    go(20001);
    chk("slow20000_pulse", bus.pulse_slow, 0);
    chk("slow20000_cpu_div", bus.cpu_div, (20001 - 17) % 8);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cur = 1;
    chk("slowrst_pulse", bus.pulse_slow, 0);
    chk("slowrst_clock", bus.clock_slow, 0);
    chk("slowrst_cpu_div", bus.cpu_div, 0);
    chk("slowrst_reset_out", bus.reset_out, 1);
    go(33332);
    chk("slow_pre_pulse", bus.pulse_slow, 0);
    go(33333);
    chk("slow_pulse", bus.pulse_slow, 1);
    chk("slow_pulse_clock", bus.clock_slow, 0);
    go(33334);
    chk("slow_post_pulse", bus.pulse_slow, 0);
    chk("slow_post_clock", bus.clock_slow, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
